// File: rtl/systolic_feeder_if.sv
// Bundle of the feeder's host-load, array-drive and result-stream signals.
// The slave modport is the feeder; the master modport is the host/array side.
interface systolic_feeder_if #(
  parameter int unsigned M          = 5,
  parameter int unsigned N          = 3,
  parameter int unsigned K          = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned AddrW = $clog2(M * N > N * K ? M * N : N * K);

  logic                         start;
  logic                         busy;
  logic                         ld_we;
  logic                         ld_sel;
  logic [AddrW-1:0]             ld_addr;
  logic [DATA_WIDTH-1:0]        ld_data;
  logic                         arr_rst_n;
  logic [DATA_WIDTH*M-1:0]      arr_x;
  logic [DATA_WIDTH*K-1:0]      arr_w;
  logic                         arr_done;
  logic [DATA_WIDTH*M*K-1:0]    arr_y;
  logic                         res_valid;
  logic                         res_ready;
  logic [DATA_WIDTH-1:0]        res_data;
  logic                         res_last;

  modport slave (
    input  start, ld_we, ld_sel, ld_addr, ld_data, arr_done, arr_y, res_ready,
    output busy, arr_rst_n, arr_x, arr_w, res_valid, res_data, res_last
  );

  modport master (
    output start, ld_we, ld_sel, ld_addr, ld_data, arr_done, arr_y, res_ready,
    input  busy, arr_rst_n, arr_x, arr_w, res_valid, res_data, res_last
  );
endinterface

// File: rtl/systolic_feeder.sv
// Host-side controller for systolic_array: buffers A/B, streams them into the array,
// captures Y on done (or watchdog expiry) and returns it as a valid/ready word stream.
module systolic_feeder #(
  parameter int unsigned M          = 5,
  parameter int unsigned N          = 3,
  parameter int unsigned K          = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  systolic_feeder_if.slave    bus
);
  localparam int unsigned AddrW   = $clog2(M * N > N * K ? M * N : N * K);
  localparam int unsigned TW      = $clog2(N + 1);
  localparam int unsigned WdLimit = M + N + K + 4;
  localparam int unsigned WdW     = $clog2(WdLimit + 1);
  localparam int unsigned NumRes  = M * K;
  localparam int unsigned IdxW    = (NumRes > 1) ? $clog2(NumRes) : 1;

  typedef enum logic [2:0] {StIdle, StFeed, StDrain, StCapture, StOut} state_e;

  state_e                state_q;
  logic [TW-1:0]         t_q;
  logic [WdW-1:0]        wd_q;
  logic [IdxW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] a_q   [M*N];
  logic [DATA_WIDTH-1:0] b_q   [N*K];
  logic [DATA_WIDTH-1:0] cap_q [NumRes];

  logic [TW-1:0]           col;
  logic [DATA_WIDTH*M-1:0] x_col;
  logic [DATA_WIDTH*K-1:0] w_col;
  logic [IdxW-1:0]         idx_nxt;
  logic [DATA_WIDTH-1:0]   word_nxt;
  logic                    hs;

  // Column for the next FEED cycle; col==N selects nothing, which zeroes the lanes on entry to DRAIN.
  always_comb begin
    col   = (state_q == StIdle) ? '0 : t_q + TW'(1);
    x_col = '0;
    w_col = '0;
    for (int n = 0; n < int'(N); n++) begin
      if (col == TW'(n)) begin
        for (int m = 0; m < int'(M); m++) begin
          x_col[m*DATA_WIDTH +: DATA_WIDTH] = a_q[m*N+n];
        end
        for (int k = 0; k < int'(K); k++) begin
          w_col[k*DATA_WIDTH +: DATA_WIDTH] = b_q[n*K+k];
        end
      end
    end
  end

  always_comb begin
    idx_nxt  = idx_q + IdxW'(1);
    word_nxt = '0;
    for (int i = 0; i < int'(NumRes); i++) begin
      if (idx_nxt == IdxW'(i)) begin
        word_nxt = cap_q[i];
      end
    end
    hs = bus.res_valid & bus.res_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      t_q           <= '0;
      wd_q          <= '0;
      idx_q         <= '0;
      bus.busy      <= 1'b0;
      bus.arr_rst_n <= 1'b0;
      bus.arr_x     <= '0;
      bus.arr_w     <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_last  <= 1'b0;
      for (int i = 0; i < int'(M * N); i++) a_q[i] <= '0;
      for (int i = 0; i < int'(N * K); i++) b_q[i] <= '0;
      for (int i = 0; i < int'(NumRes); i++) cap_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Address compare against every slot drops out-of-range writes for free.
          if (bus.ld_we) begin
            if (!bus.ld_sel) begin
              for (int i = 0; i < int'(M * N); i++) begin
                if (bus.ld_addr == AddrW'(i)) a_q[i] <= bus.ld_data;
              end
            end else begin
              for (int i = 0; i < int'(N * K); i++) begin
                if (bus.ld_addr == AddrW'(i)) b_q[i] <= bus.ld_data;
              end
            end
          end
          if (bus.start) begin
            state_q       <= StFeed;
            t_q           <= '0;
            bus.busy      <= 1'b1;
            bus.arr_rst_n <= 1'b1;
            bus.arr_x     <= x_col;
            bus.arr_w     <= w_col;
          end
        end
        StFeed: begin
          bus.arr_x <= x_col;
          bus.arr_w <= w_col;
          if (t_q == TW'(N - 1)) begin
            state_q <= StDrain;
            wd_q    <= '0;
          end else begin
            t_q <= t_q + TW'(1);
          end
        end
        StDrain: begin
          if (bus.arr_done || (wd_q == WdW'(WdLimit - 1))) begin
            state_q <= StCapture;
          end else begin
            wd_q <= wd_q + WdW'(1);
          end
        end
        StCapture: begin
          for (int i = 0; i < int'(NumRes); i++) begin
            cap_q[i] <= bus.arr_y[i*DATA_WIDTH +: DATA_WIDTH];
          end
          // Word 0 comes straight from arr_y since cap_q is only written at this edge.
          bus.res_valid <= 1'b1;
          bus.res_data  <= bus.arr_y[DATA_WIDTH-1:0];
          bus.res_last  <= (NumRes == 1);
          idx_q         <= '0;
          state_q       <= StOut;
        end
        StOut: begin
          if (hs) begin
            if (bus.res_last) begin
              state_q       <= StIdle;
              bus.busy      <= 1'b0;
              bus.arr_rst_n <= 1'b0;
              bus.res_valid <= 1'b0;
              bus.res_data  <= '0;
              bus.res_last  <= 1'b0;
            end else begin
              idx_q        <= idx_nxt;
              bus.res_data <= word_nxt;
              bus.res_last <= (idx_nxt == IdxW'(NumRes - 1));
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural accumulate-only array stub.
module tb_systolic_feeder;
  localparam int unsigned M  = 5;
  localparam int unsigned N  = 3;
  localparam int unsigned K  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = M * K;
  localparam int unsigned AW = $clog2(M * N > N * K ? M * N : N * K);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_feeder_if #(.M(M), .N(N), .K(K), .DATA_WIDTH(DW)) bus ();

  systolic_feeder #(.M(M), .N(N), .K(K), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Array stub: accumulates x*w every cycle out of reset, done after a fixed count.
  logic          done_en;
  int unsigned   arr_cnt;
  logic [DW-1:0] acc [NW];

  always_ff @(posedge clk) begin
    if (!bus.arr_rst_n) begin
      arr_cnt <= 0;
      for (int i = 0; i < int'(NW); i++) acc[i] <= '0;
    end else begin
      arr_cnt <= arr_cnt + 1;
      for (int m = 0; m < int'(M); m++)
        for (int k = 0; k < int'(K); k++)
          acc[m*K+k] <= acc[m*K+k] + bus.arr_x[m*DW +: DW] * bus.arr_w[k*DW +: DW];
    end
  end

  assign bus.arr_done = done_en && (arr_cnt >= 10);

  always_comb begin
    bus.arr_y = '0;
    for (int i = 0; i < int'(NW); i++) bus.arr_y[i*DW +: DW] = acc[i];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  logic [DW-1:0] exp_w [NW];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input bit sel, input int addr, input logic [DW-1:0] d);
    bus.ld_we   = 1'b1;
    bus.ld_sel  = sel;
    bus.ld_addr = AW'(addr);
    bus.ld_data = d;
    @(posedge clk); #1;
    bus.ld_we   = 1'b0;
  endtask

  task automatic load_t1();
    for (int m = 0; m < int'(M); m++)
      for (int n = 0; n < int'(N); n++) wr(1'b0, m * N + n, DW'(m + n + 1));
    for (int n = 0; n < int'(N); n++)
      for (int k = 0; k < int'(K); k++) wr(1'b1, n * K + k, DW'(n == k));
  endtask

  task automatic fill_exp_t1();
    for (int m = 0; m < int'(M); m++)
      for (int k = 0; k < int'(K); k++) exp_w[m*K+k] = (k < 3) ? DW'(m + k + 1) : '0;
  endtask

  // Starts a run and collects the stream; the final check lands on the cycle after res_last.
  task automatic run(input int tn, input bit toggle, input bit disturb, input bit chk_vals);
    int            nw = 0;
    int            cyc = 0;
    bit            stalled = 0;
    bit            first = 1;
    bit            rdy = 1;
    logic [DW-1:0] prev_d = '0;
    logic          prev_l = 1'b0;
    lat = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check($sformatf("t%0d accept busy", tn), bus.busy, 1);
    if (disturb) begin
      bus.start   = 1'b1;
      bus.ld_we   = 1'b1;
      bus.ld_sel  = 1'b0;
      bus.ld_addr = '0;
      bus.ld_data = 99;
    end
    while (nw < int'(NW) && cyc < 400) begin
      bus.res_ready = rdy;
      if (stalled) begin
        check($sformatf("t%0d stall valid", tn), bus.res_valid, 1);
        check($sformatf("t%0d stall data", tn), bus.res_data, prev_d);
        check($sformatf("t%0d stall last", tn), bus.res_last, prev_l);
      end
      if (bus.res_valid) begin
        first = 0;
        if (rdy) begin
          if (chk_vals) check($sformatf("t%0d word %0d", tn, nw), bus.res_data, exp_w[nw]);
          check($sformatf("t%0d last %0d", tn, nw), bus.res_last, (nw == int'(NW) - 1));
          nw++;
          stalled = 0;
        end else begin
          stalled = 1;
          prev_d  = bus.res_data;
          prev_l  = bus.res_last;
        end
      end else if (first && bus.busy) begin
        lat++;
      end
      @(posedge clk); #1;
      cyc++;
      if (disturb && cyc == 1) begin
        bus.start = 1'b0;
        bus.ld_we = 1'b0;
      end
      if (toggle) rdy = ~rdy;
    end
    bus.res_ready = 1'b1;
    check($sformatf("t%0d word count", tn), nw, NW);
    check($sformatf("t%0d idle busy", tn), bus.busy, 0);
    check($sformatf("t%0d idle valid", tn), bus.res_valid, 0);
    check($sformatf("t%0d idle arr_rst_n", tn), bus.arr_rst_n, 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.ld_we     = 1'b0;
    bus.ld_sel    = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    bus.res_ready = 1'b1;
    done_en       = 1'b1;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", bus.busy, 0);
    check("rst arr_rst_n", bus.arr_rst_n, 0);
    check("rst arr_x", DW'(|bus.arr_x), 0);
    check("rst arr_w", DW'(|bus.arr_w), 0);
    check("rst valid", bus.res_valid, 0);
    check("rst data", bus.res_data, 0);
    check("rst last", bus.res_last, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: identity-like B, always ready
    load_t1();
    fill_exp_t1();
    run(1, 1'b0, 1'b0, 1'b1);

    // 2: back-pressure every other cycle
    run(2, 1'b1, 1'b0, 1'b1);

    // 3: start and write during FEED are ignored
    run(3, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("t3 no restart", bus.busy, 0);

    // 4: reset in the second FEED cycle
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t4 busy", bus.busy, 0);
    check("t4 arr_rst_n", bus.arr_rst_n, 0);
    check("t4 arr_x", DW'(|bus.arr_x), 0);
    check("t4 arr_w", DW'(|bus.arr_w), 0);
    check("t4 valid", bus.res_valid, 0);
    check("t4 last", bus.res_last, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < int'(NW); i++) exp_w[i] = '0;
    run(40, 1'b0, 1'b0, 1'b1);
    load_t1();
    fill_exp_t1();
    run(41, 1'b0, 1'b0, 1'b1);

    // 5: array never signals done, watchdog forces capture
    done_en = 1'b0;
    run(5, 1'b0, 1'b0, 1'b0);
    check("t5 pre-output cycles", lat, N + (M + N + K + 4) + 1);
    done_en = 1'b1;

    // 6: wraparound arithmetic, back-to-back starts with no reload
    for (int i = 0; i < int'(M * N); i++) wr(1'b0, i, 32'hFFFF_FFFF);
    for (int i = 0; i < int'(N * K); i++) wr(1'b1, i, 32'd2);
    for (int i = 0; i < int'(NW); i++) exp_w[i] = 32'hFFFF_FFFA;
    run(6, 1'b0, 1'b0, 1'b1);
    run(61, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
